// File: rtl/cart_mem_arbiter.sv
// Cartridge ROM store arbiter: serialises loader writes and CPU reads onto one
// memory port, one access outstanding, with an abort timeout and sticky error.
// Optional one-entry read cache compiled in with `define CART_READ_CACHE_EN.
module cart_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ioctl_isrom,
  input  logic        i_ioctl_wr,
  input  logic [24:0] i_ioctl_addr,
  input  logic [7:0]  i_ioctl_dout,
  output logic        o_ioctl_wait,
  input  logic        i_cpu_rd,
  input  logic [24:0] i_cpu_addr,
  output logic [7:0]  o_cpu_data,
  output logic        o_cpu_wait,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [24:0] o_mem_addr,
  output logic [7:0]  o_mem_din,
  input  logic [7:0]  i_mem_dout,
  input  logic        i_mem_ack,
  output logic        o_err
);

  typedef enum logic [1:0] {StIdle, StBusyWr, StBusyRd} state_e;

  // Last BUSY cycle index; the access aborts at the end of this cycle.
  localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYC - 1);

  state_e      r_state, w_state_d;
  logic        r_wr_pend, r_rd_pend, r_cpu_rd_q, r_mem_req, r_mem_we, r_err;
  logic [24:0] r_wr_addr, r_rd_addr, r_mem_addr;
  logic [7:0]  r_wr_data, r_mem_din, r_cpu_data, r_tmo_cnt;

  logic        w_rd_rise, w_rom_rd, w_cache_hit, w_rd_miss, w_wr_accept, w_tag_hit;
  logic        w_start_wr, w_start_rd, w_done, w_timeout, w_end_rd, w_end_wr;
  logic [7:0]  w_hit_data;

  assign w_rd_rise   = i_cpu_rd & ~r_cpu_rd_q;
  assign w_rom_rd    = w_rd_rise & i_ioctl_isrom;
  assign w_cache_hit = w_rd_rise & ~i_ioctl_isrom & w_tag_hit;
  assign w_rd_miss   = w_rd_rise & ~i_ioctl_isrom & ~w_tag_hit;
  // The write holding register is free exactly when the loader is not stalled.
  assign w_wr_accept = i_ioctl_wr & ~r_wr_pend;
  assign w_end_rd    = (w_done | w_timeout) & (r_state == StBusyRd);
  assign w_end_wr    = (w_done | w_timeout) & (r_state == StBusyWr);

  assign o_ioctl_wait = r_wr_pend;
  assign o_cpu_wait   = w_rd_miss | r_rd_pend | (r_state == StBusyRd);
  assign o_cpu_data   = r_cpu_data;
  assign o_mem_req    = r_mem_req;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_din    = r_mem_din;
  assign o_err        = r_err;

  // Next-state decode: writes win over reads, BUSY ends on ack or timeout.
  always_comb begin
    w_state_d  = r_state;
    w_start_wr = 1'b0;
    w_start_rd = 1'b0;
    w_done     = 1'b0;
    w_timeout  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_wr_pend) begin
          w_state_d  = StBusyWr;
          w_start_wr = 1'b1;
        end else if (r_rd_pend) begin
          w_state_d  = StBusyRd;
          w_start_rd = 1'b1;
        end
      end
      StBusyWr, StBusyRd: begin
        if (i_mem_ack) begin
          w_state_d = StIdle;
          w_done    = 1'b1;
        end else if (r_tmo_cnt == TmoLast) begin
          w_state_d = StIdle;
          w_timeout = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State, request capture, memory port and result registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_cpu_rd_q <= 1'b0;
      r_wr_pend  <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_rd_pend  <= 1'b0;
      r_rd_addr  <= '0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_tmo_cnt  <= '0;
      r_err      <= 1'b0;
      r_cpu_data <= 8'hFF;
    end else begin
      r_state    <= w_state_d;
      r_cpu_rd_q <= i_cpu_rd;

      if (w_wr_accept) begin
        r_wr_pend <= 1'b1;
        r_wr_addr <= i_ioctl_addr;
        r_wr_data <= i_ioctl_dout;
      end else if (w_end_wr) begin
        r_wr_pend <= 1'b0;
      end

      if (w_rd_miss) begin
        r_rd_pend <= 1'b1;
        r_rd_addr <= i_cpu_addr;
      end else if (w_end_rd) begin
        r_rd_pend <= 1'b0;
      end

      if (w_start_wr) begin
        r_mem_req  <= 1'b1;
        r_mem_we   <= 1'b1;
        r_mem_addr <= r_wr_addr;
        r_mem_din  <= r_wr_data;
        r_tmo_cnt  <= '0;
      end else if (w_start_rd) begin
        r_mem_req  <= 1'b1;
        r_mem_we   <= 1'b0;
        r_mem_addr <= r_rd_addr;
        r_tmo_cnt  <= '0;
      end else if (w_done | w_timeout) begin
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
      end else if (r_state != StIdle) begin
        r_tmo_cnt <= r_tmo_cnt + 8'd1;
      end

      if (w_timeout) r_err <= 1'b1;

      if (w_end_rd && w_done) begin
        r_cpu_data <= i_mem_dout;
      end else if (w_end_rd || w_rom_rd) begin
        r_cpu_data <= 8'hFF;
      end else if (w_cache_hit) begin
        r_cpu_data <= w_hit_data;
      end
    end
  end

`ifdef CART_READ_CACHE_EN
  logic        r_cache_valid, r_isrom_q;
  logic [24:0] r_cache_tag;
  logic [7:0]  r_cache_data;

  assign w_tag_hit  = r_cache_valid & (i_cpu_addr == r_cache_tag);
  assign w_hit_data = r_cache_data;

  // One-entry cache; invalidation beats a same-cycle fill so stale data never survives.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cache_valid <= 1'b0;
      r_isrom_q     <= 1'b0;
      r_cache_tag   <= '0;
      r_cache_data  <= 8'hFF;
    end else begin
      r_isrom_q <= i_ioctl_isrom;
      if (w_wr_accept || (i_ioctl_isrom && !r_isrom_q) || w_timeout) begin
        r_cache_valid <= 1'b0;
      end else if (w_end_rd && w_done) begin
        r_cache_valid <= 1'b1;
        r_cache_tag   <= r_mem_addr;
        r_cache_data  <= i_mem_dout;
      end
    end
  end
`else
  assign w_tag_hit  = 1'b0;
  assign w_hit_data = 8'hFF;
`endif

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Self-checking bench for cart_mem_arbiter: table of CPU reads plus hand-written
// load, collision, timeout, ROM-mode, reset and cache sequences. A memory
// responder checks every access against a queue of expected accesses.
`timescale 1ns/1ps
module tb_cart_mem_arbiter;

  logic        clk = 1'b0;
  logic        i_reset, i_ioctl_isrom, i_ioctl_wr, i_cpu_rd, i_mem_ack;
  logic [24:0] i_ioctl_addr, i_cpu_addr;
  logic [7:0]  i_ioctl_dout, i_mem_dout;
  logic        o_ioctl_wait, o_cpu_wait, o_mem_req, o_mem_we, o_err;
  logic [7:0]  o_cpu_data, o_mem_din;
  logic [24:0] o_mem_addr;

  always #5 clk = ~clk;

  cart_mem_arbiter #(.TIMEOUT_CYC(8)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_ioctl_isrom(i_ioctl_isrom),
    .i_ioctl_wr   (i_ioctl_wr),
    .i_ioctl_addr (i_ioctl_addr),
    .i_ioctl_dout (i_ioctl_dout),
    .o_ioctl_wait (o_ioctl_wait),
    .i_cpu_rd     (i_cpu_rd),
    .i_cpu_addr   (i_cpu_addr),
    .o_cpu_data   (o_cpu_data),
    .o_cpu_wait   (o_cpu_wait),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_din    (o_mem_din),
    .i_mem_dout   (i_mem_dout),
    .i_mem_ack    (i_mem_ack),
    .o_err        (o_err)
  );

  typedef struct {
    logic        we;
    logic [24:0] addr;
    logic [7:0]  din;
    logic        chk_din;
  } acc_t;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  dout;
    int          dly;
    logic [7:0]  exp_data;
    int          exp_wait;
  } rd_vec_t;

  acc_t        exp_q[$];
  rd_vec_t     rd_tab[4];
  int          errors = 0;
  int          checks = 0;
  int          n_acc = 0;
  int          req_cyc = 0;
  int          ack_dly = 0;
  bit          in_acc = 0;
  bit          ack_en = 1;
  bit          stray_ack = 0;
  logic [7:0]  rsp_data = 8'h00;
  logic [24:0] cur_addr = '0;
  logic        smp_wait, smp_req, smp_iowait, smp_err;
  logic [7:0]  smp_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: responder and sampling at negedge, ack cleared just after posedge.
  task automatic step();
    acc_t e;
    @(negedge clk);
    if (o_mem_req === 1'b1) begin
      if (!in_acc) begin
        in_acc = 1; req_cyc = 0; n_acc++; cur_addr = o_mem_addr;
        check("access_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("mem_we", o_mem_we, e.we);
          check("mem_addr", o_mem_addr, e.addr);
          if (e.chk_din) check("mem_din", o_mem_din, e.din);
        end
      end else begin
        check("mem_addr_hold", o_mem_addr, cur_addr);
      end
      if (ack_en && req_cyc == ack_dly) begin
        i_mem_ack = 1'b1; i_mem_dout = rsp_data;
      end
      req_cyc++;
    end else begin
      in_acc = 0;
    end
    if (stray_ack) begin
      i_mem_ack = 1'b1; i_mem_dout = rsp_data;
    end
    smp_wait = o_cpu_wait; smp_req = o_mem_req; smp_iowait = o_ioctl_wait;
    smp_err = o_err; smp_data = o_cpu_data;
    @(posedge clk);
    #1;
    i_mem_ack = 1'b0;
  endtask

  // CPU read: counts cpu_wait and mem_req cycles; data is sampled after cpu_rd drops.
  task automatic do_read(input logic [24:0] a, input logic [7:0] dv, input int dly,
                         input bit expect_acc, output int wcnt, output int rcnt,
                         output logic [7:0] data, output bit fin);
    ack_dly = dly; rsp_data = dv; i_cpu_addr = a; i_cpu_rd = 1'b1;
    if (expect_acc) exp_q.push_back('{1'b0, a, 8'h00, 1'b0});
    wcnt = 0; rcnt = 0; fin = 0;
    for (int c = 0; c < 40 && !fin; c++) begin
      step();
      if (smp_req) rcnt++;
      if (smp_wait) wcnt++;
      else fin = 1;
    end
    i_cpu_rd = 1'b0;
    step();
    data = smp_data;
  endtask

  // Loader write; with dup the loader re-strobes a different write while stalled.
  task automatic do_load(input logic [24:0] a, input logic [7:0] dv, input int dly,
                         input bit dup, output int wcnt, output bit fin);
    ack_dly = dly;
    exp_q.push_back('{1'b1, a, dv, 1'b1});
    i_ioctl_addr = a; i_ioctl_dout = dv; i_ioctl_wr = 1'b1;
    step();
    check("load_wait_accept_cycle", smp_iowait, 0);
    if (dup) begin
      i_ioctl_addr = a ^ 25'h30; i_ioctl_dout = ~dv;
    end else begin
      i_ioctl_wr = 1'b0;
    end
    wcnt = 0; fin = 0;
    for (int c = 0; c < 40 && !fin; c++) begin
      step();
      i_ioctl_wr = 1'b0;
      if (smp_iowait) wcnt++;
      else fin = 1;
    end
  endtask

  initial begin
    int         w, r, acc0;
    logic [7:0] d;
    bit         f;

    i_reset = 1'b1; i_ioctl_isrom = 1'b0; i_ioctl_wr = 1'b0; i_cpu_rd = 1'b0;
    i_mem_ack = 1'b0; i_ioctl_addr = '0; i_cpu_addr = '0; i_ioctl_dout = '0;
    i_mem_dout = '0;

    rd_tab[0] = '{25'h0004000, 8'h3C, 0, 8'h3C, 3};
    rd_tab[1] = '{25'h1FFFFFF, 8'hC3, 1, 8'hC3, 4};
    rd_tab[2] = '{25'h0000000, 8'h00, 2, 8'h00, 5};
    rd_tab[3] = '{25'h0ABCDEF, 8'h7E, 0, 8'h7E, 3};

    step(); step();
    i_reset = 1'b0;
    step();
    check("rst_cpu_data", smp_data, 8'hFF);
    check("rst_err", smp_err, 0);
    check("rst_mem_req", smp_req, 0);
    check("rst_cpu_wait", smp_wait, 0);
    check("rst_ioctl_wait", smp_iowait, 0);
    check("rst_mem_addr", o_mem_addr, 0);
    check("rst_mem_din", o_mem_din, 0);
    check("rst_mem_we", o_mem_we, 0);

    // ROM load with a dropped second strobe, ack on the second mem_req cycle.
    i_ioctl_isrom = 1'b1;
    acc0 = n_acc;
    do_load(25'h0000010, 8'hA5, 1, 1, w, f);
    check("load_done", f, 1);
    check("load_wait_cycles", w, 3);
    check("load_access_count", n_acc - acc0, 1);
    check("load_queue_empty", exp_q.size(), 0);
    i_ioctl_isrom = 1'b0;
    step();

    // Table of CPU reads.
    foreach (rd_tab[i]) begin
      do_read(rd_tab[i].addr, rd_tab[i].dout, rd_tab[i].dly, 1, w, r, d, f);
      check("read_done", f, 1);
      check("read_wait_cycles", w, rd_tab[i].exp_wait);
      check("read_data", d, rd_tab[i].exp_data);
      check("read_queue_empty", exp_q.size(), 0);
    end

    // Read while a ROM image is loading: no access, 0xFF, no stall.
    i_ioctl_isrom = 1'b1;
    acc0 = n_acc;
    do_read(25'h0000555, 8'h12, 0, 0, w, r, d, f);
    check("rom_read_wait", w, 0);
    check("rom_read_data", d, 8'hFF);
    check("rom_read_no_access", n_acc - acc0, 0);
    i_ioctl_isrom = 1'b0;
    step();

    // Write and read event in the same cycle: write served first, then read.
    ack_dly = 0; rsp_data = 8'h6B; acc0 = n_acc;
    exp_q.push_back('{1'b1, 25'h0000030, 8'h77, 1'b1});
    exp_q.push_back('{1'b0, 25'h0000400, 8'h00, 1'b0});
    i_ioctl_addr = 25'h0000030; i_ioctl_dout = 8'h77; i_ioctl_wr = 1'b1;
    i_cpu_addr = 25'h0000400; i_cpu_rd = 1'b1;
    w = 0; f = 0;
    for (int c = 0; c < 40 && !f; c++) begin
      step();
      i_ioctl_wr = 1'b0;
      if (smp_wait) w++;
      if (!smp_wait && !smp_iowait) f = 1;
    end
    check("coll_done", f, 1);
    check("coll_wait_cycles", w, 5);
    check("coll_data", smp_data, 8'h6B);
    check("coll_access_count", n_acc - acc0, 2);
    check("coll_queue_empty", exp_q.size(), 0);
    i_cpu_rd = 1'b0;
    step();

    // Timeout: never ack.
    ack_en = 0;
    do_read(25'h0000123, 8'h00, 0, 1, w, r, d, f);
    check("tmo_done", f, 1);
    check("tmo_req_cycles", r, 8);
    check("tmo_wait_cycles", w, 10);
    check("tmo_data", d, 8'hFF);
    check("tmo_err", smp_err, 1);
    ack_en = 1;
    step(); step();
    check("tmo_err_sticky", smp_err, 1);
    do_read(25'h0000124, 8'h99, 0, 1, w, r, d, f);
    check("post_tmo_data", d, 8'h99);
    check("post_tmo_err_sticky", smp_err, 1);

    // Reset in BUSY_RD followed by a stray ack.
    ack_en = 0;
    exp_q.push_back('{1'b0, 25'h0001234, 8'h00, 1'b0});
    i_cpu_addr = 25'h0001234; i_cpu_rd = 1'b1;
    smp_req = 1'b0;
    for (int c = 0; c < 10 && !smp_req; c++) step();
    check("rstbusy_reached", smp_req, 1);
    i_reset = 1'b1; i_cpu_rd = 1'b0;
    step();
    i_reset = 1'b0; stray_ack = 1; rsp_data = 8'h42;
    step();
    stray_ack = 0; ack_en = 1;
    check("rstbusy_mem_req", smp_req, 0);
    check("rstbusy_cpu_wait", smp_wait, 0);
    check("rstbusy_cpu_data", smp_data, 8'hFF);
    check("rstbusy_err", smp_err, 0);
    check("rstbusy_ioctl_wait", smp_iowait, 0);
    step();
    check("stray_cpu_data", smp_data, 8'hFF);
    check("stray_mem_req", smp_req, 0);
    check("stray_cpu_wait", smp_wait, 0);
    check("stray_mem_addr", o_mem_addr, 0);
    check("stray_mem_we", o_mem_we, 0);
    check("rstbusy_queue_empty", exp_q.size(), 0);

`ifdef CART_READ_CACHE_EN
    do_read(25'h0008001, 8'h5D, 0, 1, w, r, d, f);
    check("cache_miss_data", d, 8'h5D);
    acc0 = n_acc;
    do_read(25'h0008001, 8'h00, 0, 0, w, r, d, f);
    check("cache_hit_wait", w, 0);
    check("cache_hit_data", d, 8'h5D);
    check("cache_hit_no_access", n_acc - acc0, 0);
    do_load(25'h0000040, 8'h01, 0, 0, w, f);
    check("cache_inval_load_done", f, 1);
    do_read(25'h0008001, 8'h6E, 0, 1, w, r, d, f);
    check("cache_refill_wait", w, 3);
    check("cache_refill_data", d, 8'h6E);
`else
    acc0 = n_acc;
    do_read(25'h0008001, 8'h5D, 0, 1, w, r, d, f);
    check("nocache_first_data", d, 8'h5D);
    do_read(25'h0008001, 8'h6E, 0, 1, w, r, d, f);
    check("nocache_second_wait", w, 3);
    check("nocache_second_data", d, 8'h6E);
    check("nocache_access_count", n_acc - acc0, 2);
`endif
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
